// File: rtl/ped_request_arbiter.sv
// ped_request_arbiter: debounced pedestrian button capture with round-robin grant/ack/timeout arbitration.
// Optional build macro PED_PRIORITY_MAIN_EN: when defined, pending north/south requests are
// arbitrated ahead of east/west; when undefined, all four directions share one round-robin.
module ped_request_arbiter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [3:0] push,
  input  logic [3:0] walk_ack,
  output logic [3:0] pending,
  output logic [3:0] grant,
  output logic       enable_P,
  output logic       timeout_err
);
  typedef enum logic [1:0] {IDLE, REQ, WALK} state_t;
  state_t          state_q, state_d;
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0][3:0] cnt_q, cnt_d;
  logic [3:0]      db, db_q, press;
  logic [3:0]      pending_q, pending_d, clr;
  logic [3:0]      grant_q, grant_d, ack_q, cand;
  logic [1:0]      rr_ptr_q, rr_ptr_d, g_q, g_d, sel;
  logic [7:0]      wait_q, wait_d;
  logic            enable_q, timeout_q, timeout_d;
  // Debounce: count synchronised-high cycles, saturate at the threshold, clear on any low
  always_comb begin
    cnt_d = cnt_q;
    db    = '0;
    for (int i = 0; i < 4; i++) begin
      db[i]    = sync2_q[i] && (cnt_q[i] == 4'(DEBOUNCE_CYCLES));
      cnt_d[i] = !sync2_q[i] ? 4'd0 : (cnt_q[i] == 4'(DEBOUNCE_CYCLES)) ? cnt_q[i] : cnt_q[i] + 4'd1;
    end
  end
  assign press = db & ~db_q;
  // Candidate set for arbitration; main-street requests may shadow the cross street
  always_comb begin
`ifdef PED_PRIORITY_MAIN_EN
    cand = |pending_q[1:0] ? {2'b00, pending_q[1:0]} : pending_q;
`else
    cand = pending_q;
`endif
  end
  // Round-robin pick: first candidate at or after rr_ptr, scanning upward with 2-bit wrap
  always_comb begin
    sel = rr_ptr_q;
    for (int k = 3; k >= 0; k--)
      if (cand[rr_ptr_q + 2'(k)]) sel = rr_ptr_q + 2'(k);
  end
  // Grant FSM next state: IDLE picks, REQ waits for ack or times out, WALK waits for ack fall
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    g_d       = g_q;
    rr_ptr_d  = rr_ptr_q;
    wait_d    = wait_q;
    timeout_d = 1'b0;
    clr       = '0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (|cand) begin
          grant_d = 4'b0001 << sel;
          g_d     = sel;
          wait_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        wait_d = wait_q + 8'd1;
        if (walk_ack[g_q]) state_d = WALK;
        else if (wait_q == 8'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          rr_ptr_d  = g_q + 2'd1;
          state_d   = IDLE;
        end
      end
      WALK: begin
        if (ack_q[g_q] && !walk_ack[g_q]) begin
          clr      = 4'b0001 << g_q;
          grant_d  = '0;
          rr_ptr_d = g_q + 2'd1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // A press is absorbed when that direction's walk is already active; completion clear wins
  assign pending_d = (pending_q | (press & ~walk_ack)) & ~clr;
  // State registers; the asynchronous reset drops every request and grant at once
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      db_q      <= '0;
      pending_q <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      rr_ptr_q  <= '0;
      g_q       <= '0;
      wait_q    <= '0;
      enable_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= push;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      db_q      <= db;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      ack_q     <= walk_ack;
      rr_ptr_q  <= rr_ptr_d;
      g_q       <= g_d;
      wait_q    <= wait_d;
      enable_q  <= |grant_d;
      timeout_q <= timeout_d;
    end
  end
  assign pending     = pending_q;
  assign grant       = grant_q;
  assign enable_P    = enable_q;
  assign timeout_err = timeout_q;
endmodule

// File: tb/tb_ped_request_arbiter.sv
// tb_ped_request_arbiter: directed scoreboard bench for ped_request_arbiter.
module tb_ped_request_arbiter;
  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic [3:0] push = '0;
  logic [3:0] walk_ack = '0;
  logic [3:0] pending, grant;
  logic       enable_P, timeout_err;
  int         n_assert = 0;
  int         n_fail = 0;
  logic [3:0] exp_q[$];

  ped_request_arbiter dut (
    .clk(clk), .rst_a(rst_a), .push(push), .walk_ack(walk_ack),
    .pending(pending), .grant(grant), .enable_P(enable_P), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_a = 1'b1;
    push = '0;
    walk_ack = '0;
    exp_q.delete();
    tick(2);
    rst_a = 1'b0;
  endtask

  task automatic press(logic [3:0] m, logic [3:0] exp_grant_first);
    if (exp_grant_first != '0) exp_q.push_back(exp_grant_first);
    push = m;
    tick(8);
    push = '0;
  endtask

  task automatic wait_grant(string tag);
    logic [3:0] e;
    int n = 0;
    while (grant == '0 && n < 200) begin
      tick();
      n++;
    end
    e = exp_q.size() != 0 ? exp_q.pop_front() : 4'b0000;
    chk({tag, " grant"}, 8'(grant), 8'(e));
    chk({tag, " enable"}, 8'(enable_P), 8'd1);
  endtask

  task automatic serve(string tag);
    wait_grant(tag);
    walk_ack = grant;
    tick(3);
    walk_ack = '0;
    tick();
    chk({tag, " release"}, 8'(grant), 8'd0);
  endtask

  initial begin
    do_reset();
    chk("reset pending", 8'(pending), 8'd0);
    chk("reset grant", 8'(grant), 8'd0);
    chk("reset enable", 8'(enable_P), 8'd0);
    chk("reset timeout", 8'(timeout_err), 8'd0);

    push = 4'b0001;
    tick(6);
    chk("press latency early", 8'(pending), 8'd0);
    tick();
    chk("press latency", 8'(pending), 8'h1);
    chk("no grant yet", 8'(grant), 8'd0);
    exp_q.push_back(4'b0001);
    tick();
    wait_grant("clean press");
    walk_ack = 4'b0001;
    tick(2);
    push = '0;
    tick(6);
    chk("walk hold grant", 8'(grant), 8'h1);
    walk_ack = '0;
    tick();
    chk("walk done pending", 8'(pending), 8'd0);
    chk("walk done grant", 8'(grant), 8'd0);
    chk("walk done enable", 8'(enable_P), 8'd0);

    for (int i = 0; i < 5; i++) begin
      push = 4'b0100;
      tick(2);
      push = '0;
      tick(2);
    end
    tick(5);
    chk("bounce pending", 8'(pending), 8'd0);
    chk("bounce grant", 8'(grant), 8'd0);

    do_reset();
    press(4'b1111, 4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    serve("rr north");
    serve("rr south");
    serve("rr east");
    serve("rr west");
    chk("rr all served", 8'(pending), 8'd0);
    press(4'b0001, 4'b0001);
    serve("rr wrap north");

    push = 4'b0001;
    exp_q.push_back(4'b0001);
    tick(8);
    push = '0;
    chk("to grant", 8'(grant), 8'(exp_q.pop_front()));
    tick(63);
    chk("to before", 8'(timeout_err), 8'd0);
    chk("to still granted", 8'(grant), 8'h1);
    tick();
    chk("to pulse", 8'(timeout_err), 8'd1);
    chk("to grant dropped", 8'(grant), 8'd0);
    chk("to pending kept", 8'(pending), 8'h1);
    tick();
    chk("to single pulse", 8'(timeout_err), 8'd0);
    exp_q.push_back(4'b0001);
    serve("to regrant");

    walk_ack = 4'b0100;
    push = 4'b0100;
    tick(8);
    push = '0;
    chk("absorb pending", 8'(pending), 8'd0);
    walk_ack = '0;
    tick(3);
    chk("absorb after", 8'(pending), 8'd0);
    chk("absorb grant", 8'(grant), 8'd0);

    press(4'b0010, 4'b0010);
    wait_grant("pre reset");
    tick(2);
    #2;
    rst_a = 1'b1;
    #1;
    chk("async grant", 8'(grant), 8'd0);
    chk("async enable", 8'(enable_P), 8'd0);
    chk("async pending", 8'(pending), 8'd0);
    @(posedge clk);
    #1;
    rst_a = 1'b0;

    do_reset();
    press(4'b1100, 4'b0100);
    wait_grant("prio east");
    walk_ack = 4'b0100;
    tick();
    push = 4'b0010;
    tick(8);
    push = '0;
    chk("prio pending", 8'(pending), 8'hE);
    walk_ack = '0;
    tick();
    chk("prio east release", 8'(grant), 8'd0);
`ifdef PED_PRIORITY_MAIN_EN
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
`else
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010);
`endif
    serve("prio second");
    serve("prio third");
    chk("prio final pending", 8'(pending), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
